// File: rtl/graph_pkg.sv
// Shared definitions for the clique-counter graph interface: FSM state encoding and
// the flat adjacency index used by both the edge loader and the clique counter.
package graph_pkg;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    S_LOAD  = ST_LOAD,
    S_CLEAR = ST_CLEAR,
    S_HOLD  = ST_HOLD
  } state_e;

  // Bit position of adjacency entry (row, col) in an n x n flat matrix.
  function automatic int flat_idx(input int row, input int col, input int n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/graph_row_clear.sv
// Row sequencer for the post-ack clear sweep: walks rows 0..N-1, one per cycle,
// and flags the final row so the loader can return to LOAD.
module graph_row_clear #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IDX_W-1:0] row,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(N - 1);

  logic [IDX_W-1:0] row_q, row_d;
  logic             active_q, active_d;

  always_comb begin
    row_d    = row_q;
    active_d = active_q;
    if (start) begin
      row_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (row_q == LAST_ROW) begin
        row_d    = '0;
        active_d = 1'b0;
      end else begin
        row_d = row_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q    <= '0;
      active_q <= 1'b0;
    end else begin
      row_q    <= row_d;
      active_q <= active_d;
    end
  end

  assign row  = row_q;
  assign done = active_q && (row_q == LAST_ROW);

endmodule

// File: rtl/graph_edge_loader.sv
// Builds a symmetric N x N adjacency matrix from a stream of undirected edges.
// Optional GRAPH_LOADER_SELF_LOOP_REJECT_EN drops u==v edges and flags err_range.
//
// Handshakes: an edge beat transfers on a rising edge where edge_valid && edge_ready;
// edge_u/edge_v/edge_last must be stable while edge_valid is high. graph is complete
// and frozen while graph_valid is high; a graph_ack sampled high in that window
// releases it and starts the clear sweep. graph_ack at any other time is ignored.
module graph_edge_loader
  import graph_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1,
  parameter int CNT_W = $clog2(N * N + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               edge_valid,
  output logic               edge_ready,
  input  logic [IDX_W-1:0]   edge_u,
  input  logic [IDX_W-1:0]   edge_v,
  input  logic               edge_last,
  output logic [N*N-1:0]     graph,
  output logic               graph_valid,
  input  logic               graph_ack,
  output logic [CNT_W-1:0]   edge_count,
  output logic               err_range,
  output logic [1:0]         dbg_state
);

  localparam int               NN       = N * N;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NN);
  localparam logic [NN-1:0]    ROW_MASK = NN'({N{1'b1}});

  state_e             state_q, state_d;
  logic [NN-1:0]      graph_q, graph_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               err_q, err_d;
  logic               graph_valid_q, graph_valid_d;
  logic               edge_ready_q, edge_ready_d;

  logic               accept;
  logic               in_range;
  logic               self_loop_bad;
  logic               edge_ok;
  logic [NN-1:0]      mask_uv, mask_vu;
  logic               clr_start;
  logic [IDX_W-1:0]   clr_row;
  logic               clr_done;

  graph_row_clear #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_row_clear (
    .clk   (clk),
    .rst   (rst),
    .start (clr_start),
    .row   (clr_row),
    .done  (clr_done)
  );

  assign accept   = edge_valid && edge_ready_q;
  assign in_range = (int'(edge_u) < N) && (int'(edge_v) < N);
`ifdef GRAPH_LOADER_SELF_LOOP_REJECT_EN
  assign self_loop_bad = (edge_u == edge_v);
`else
  assign self_loop_bad = 1'b0;
`endif
  assign edge_ok  = in_range && !self_loop_bad;
  assign mask_uv  = NN'(1) << flat_idx(int'(edge_u), int'(edge_v), N);
  assign mask_vu  = NN'(1) << flat_idx(int'(edge_v), int'(edge_u), N);

  always_comb begin
    state_d   = state_q;
    graph_d   = graph_q;
    count_d   = count_q;
    err_d     = err_q;
    clr_start = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (accept) begin
          if (edge_ok) begin
            graph_d = graph_q | mask_uv | mask_vu;
            // The reversed pair hits the same bit via symmetry, so it never counts twice.
            if (((graph_q & mask_uv) == '0) && (count_q < CNT_MAX)) begin
              count_d = count_q + CNT_W'(1);
            end
          end else begin
            err_d = 1'b1;
          end
          if (edge_last) begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (graph_ack) begin
          state_d   = S_CLEAR;
          count_d   = '0;
          err_d     = 1'b0;
          clr_start = 1'b1;
        end
      end
      S_CLEAR: begin
        graph_d = graph_q & ~(ROW_MASK << flat_idx(int'(clr_row), 0, N));
        if (clr_done) begin
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
    graph_valid_d = (state_d == S_HOLD);
    edge_ready_d  = (state_d == S_LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_LOAD;
      graph_q       <= '0;
      count_q       <= '0;
      err_q         <= 1'b0;
      graph_valid_q <= 1'b0;
      edge_ready_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      graph_q       <= graph_d;
      count_q       <= count_d;
      err_q         <= err_d;
      graph_valid_q <= graph_valid_d;
      edge_ready_q  <= edge_ready_d;
    end
  end

  assign edge_ready  = edge_ready_q;
  assign graph       = graph_q;
  assign graph_valid = graph_valid_q;
  assign edge_count  = count_q;
  assign err_range   = err_q;
  assign dbg_state   = state_q;

endmodule
